mc_control: RTL and testbench
=============================

Name: mc_control

Overview:
- Multi-cycle MIPS control unit; successor to the single-cycle combinational decoder.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Stalls on a memory ready handshake, decodes R-type funct into alu_ctrl, and traps illegal encodings.
- Sits between the instruction register (op/funct) and the shared-memory multi-cycle datapath.

Parameters:
- ALU_W, 4, alu_ctrl width (codes below are zero-extended to ALU_W).
- OP_LW, 6'b100011, load opcode.
- OP_SW, 6'b101011, store opcode.
- OP_BEQ, 6'b000100, branch-equal opcode.
- OP_J, 6'b000010, jump opcode.
- OP_ADDI, 6'b001000, add-immediate opcode.
- TIMEOUT_CYC, 16, memory wait limit in cycles; used only with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  level; leave IDLE and start fetching.
- op  in  6  instruction[31:26].
- funct  in  6  instruction[5:0].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- state  out  4  current state encoding, for debug.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- i_or_d  out  1  0 = PC address, 1 = ALUOut address.
- ir_write  out  1  load the instruction register.
- pc_write  out  1  load the PC.
- pc_src  out  2  PC source: 0 = ALU, 1 = ALUOut, 2 = jump target.
- alu_src_a  out  1  0 = PC, 1 = rs.
- alu_src_b  out  2  0 = rt, 1 = constant 4, 2 = sign-extended immediate, 3 = shifted immediate.
- alu_ctrl  out  ALU_W  ALU operation.
- reg_dest  out  1  1 = rd, 0 = rt.
- reg_write  out  1  register file write enable.
- mem_to_reg  out  1  1 = MDR, 0 = ALUOut.
- instr_done  out  1  one-cycle pulse on instruction retire.
- illegal_op  out  1  one-cycle pulse in TRAP.
- mem_err  out  1  sticky timeout flag.

Behaviour:
- State encodings: IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_RD=4, MEM_WB=5, MEM_WR=6, R_EXEC=7, R_WB=8, BRANCH=9, JUMP=10, I_EXEC=11, I_WB=12, TRAP=13.
- Reset: async to IDLE. In IDLE every output is 0, including mem_err. Outputs decode combinationally from state, plus mem_ready/zero where noted.
- IDLE -> FETCH when run=1. run is sampled only in IDLE.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=1, alu_ctrl=0010, pc_src=0.
  - ir_write and pc_write equal mem_ready.
  - Stay in FETCH while mem_ready=0; go to DECODE on mem_ready=1.
- DECODE: alu_src_a=0, alu_src_b=3, alu_ctrl=0010.
  - lw/sw -> MEM_ADDR; R-type (op=0) -> R_EXEC; beq -> BRANCH; j -> JUMP; addi -> I_EXEC; any other op -> TRAP.
- MEM_ADDR: alu_src_a=1, alu_src_b=2, alu_ctrl=0010; lw -> MEM_RD, sw -> MEM_WR.
- MEM_RD: mem_read=1, i_or_d=1; wait for mem_ready, then -> MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dest=0, instr_done=1 -> FETCH.
- MEM_WR: mem_write=1, i_or_d=1; instr_done=mem_ready; -> FETCH on mem_ready.
- R_EXEC: alu_src_a=1, alu_src_b=0. alu_ctrl from funct:
  - 100000 -> 0010; 100010 -> 0110; 100100 -> 0000; 100101 -> 0001; 101010 -> 0111.
  - Any other funct -> TRAP, with alu_ctrl=0.
  - Valid funct -> R_WB.
- R_WB: reg_write=1, reg_dest=1, mem_to_reg=0, instr_done=1 -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=0, alu_ctrl=0110, pc_src=1, pc_write=zero, instr_done=1 -> FETCH.
- JUMP: pc_src=2, pc_write=1, instr_done=1 -> FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=2, alu_ctrl=0010 -> I_WB.
- I_WB: reg_write=1, reg_dest=0, mem_to_reg=0, instr_done=1 -> FETCH.
- TRAP: illegal_op=1; no writes, no PC update -> FETCH. The faulting instruction is skipped because PC was already advanced in FETCH.
- Latency with mem_ready=1 immediately:
  - lw 5 cycles; sw, R-type, addi 4; beq, j 3.
  - Each wait cycle adds 1.
- mem_read and mem_write are never both 1. Request outputs hold stable while waiting.
- Reset mid-instruction: immediate return to IDLE with all outputs 0. The memory request drops asynchronously.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - A counter increments in FETCH, MEM_RD and MEM_WR while mem_ready=0, and clears on state change.
  - When it reaches TIMEOUT_CYC-1 with mem_ready still 0, go to TRAP on the next edge, set mem_err=1, and pulse illegal_op.
  - mem_err clears only on reset.
- MEM_TIMEOUT_EN undefined: waits are unbounded, mem_err is tied 0, and no counter logic is present.

Test Plan:
- Reset with rst_n=0 mid-R_EXEC -> state=0 and all outputs 0 asynchronously. Release rst_n with run=0 -> stays IDLE.
- run=1, op=100011, mem_ready=1 constant -> states 1,2,3,4,5,1. reg_write=1 and mem_to_reg=1 only in state 5. instr_done pulses once.
- op=0, funct=100010 -> alu_ctrl=0110 in R_EXEC, then R_WB with reg_dest=1. Repeat with funct=000111 -> TRAP and illegal_op=1 for one cycle.
- op=000100, zero=1 then zero=0 -> pc_write=1 / 0 in BRANCH with pc_src=1. Both cases go to FETCH after 3 cycles.
- op=101011, mem_ready low for 3 cycles in MEM_WR -> mem_write held high 4 cycles, instr_done only in the ready cycle, 7 cycles total.
- With MEM_TIMEOUT_EN and TIMEOUT_CYC=16, mem_ready=0 in FETCH -> TRAP after 16 cycles, mem_err=1 stays high until reset. Without the macro the block remains in FETCH.

Source files
------------

// File: rtl/mc_control.sv
// mc_control: multi-cycle MIPS control unit.
//
// Walks each instruction through FETCH, DECODE and the per-class execute,
// memory and writeback states. It stalls on the memory ready handshake,
// decodes the R-type funct field into alu_ctrl, and traps illegal encodings.
// Datapath controls are decoded combinationally from the state register.
// Some of them also depend on mem_ready or zero.
//
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   run                leave IDLE and start fetching (sampled only in IDLE)
//   op, funct          instruction[31:26] and instruction[5:0]
//   zero               ALU zero flag (branch decision)
//   mem_ready          memory completes the current access this cycle
//   state              current state encoding (debug)
//   mem_read/mem_write memory requests; i_or_d selects PC (0) or ALUOut (1)
//   ir_write, pc_write IR and PC load enables; pc_src selects the PC source
//   alu_src_a/b        ALU operand selects; alu_ctrl is the ALU operation
//   reg_dest, reg_write, mem_to_reg  register file write controls
//   instr_done         one-cycle pulse when an instruction retires
//   illegal_op         one-cycle pulse in TRAP
//   mem_err            sticky memory timeout flag
//
// Optional feature: define MEM_TIMEOUT_EN to bound memory waits.
// After TIMEOUT_CYC stalled cycles the unit traps and sets mem_err.
// Without the macro, waits are unbounded and mem_err is tied to 0.

module mc_control #(
    parameter int unsigned ALU_W       = 4,
    parameter logic [5:0]  OP_LW       = 6'b100011,
    parameter logic [5:0]  OP_SW       = 6'b101011,
    parameter logic [5:0]  OP_BEQ      = 6'b000100,
    parameter logic [5:0]  OP_J        = 6'b000010,
    parameter logic [5:0]  OP_ADDI     = 6'b001000,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic [3:0]       state,
    output logic             mem_read,
    output logic             mem_write,
    output logic             i_or_d,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [ALU_W-1:0] alu_ctrl,
    output logic             reg_dest,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             instr_done,
    output logic             illegal_op,
    output logic             mem_err
);

    typedef enum logic [3:0] {
        StIdle    = 4'd0,
        StFetch   = 4'd1,
        StDecode  = 4'd2,
        StMemAddr = 4'd3,
        StMemRd   = 4'd4,
        StMemWb   = 4'd5,
        StMemWr   = 4'd6,
        StRExec   = 4'd7,
        StRWb     = 4'd8,
        StBranch  = 4'd9,
        StJump    = 4'd10,
        StIExec   = 4'd11,
        StIWb     = 4'd12,
        StTrap    = 4'd13
    } state_e;

    localparam logic [ALU_W-1:0] AluAnd = ALU_W'(4'b0000);
    localparam logic [ALU_W-1:0] AluOr  = ALU_W'(4'b0001);
    localparam logic [ALU_W-1:0] AluAdd = ALU_W'(4'b0010);
    localparam logic [ALU_W-1:0] AluSub = ALU_W'(4'b0110);
    localparam logic [ALU_W-1:0] AluSlt = ALU_W'(4'b0111);

    state_e state_q;

    // R-type funct decode, shared by the R_EXEC outputs and its next state.
    logic [ALU_W-1:0] r_alu;
    logic             r_valid;

    always_comb begin
        r_alu   = '0;
        r_valid = 1'b1;
        case (funct)
            6'b100000: r_alu = AluAdd;
            6'b100010: r_alu = AluSub;
            6'b100100: r_alu = AluAnd;
            6'b100101: r_alu = AluOr;
            6'b101010: r_alu = AluSlt;
            default:   r_valid = 1'b0;
        endcase
    end

    logic timeout;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CNT_W-1:0] wait_cnt_q;
    logic             mem_err_q;
    logic             waiting;

    assign waiting = ((state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr))
                     && !mem_ready;
    assign timeout = waiting && (wait_cnt_q == CNT_W'(TIMEOUT_CYC - 1));
    assign mem_err = mem_err_q;

    // A wait that does not time out keeps the state unchanged. Every other
    // case is a state change or a non-waiting state, so the count restarts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            if (waiting && !timeout) wait_cnt_q <= wait_cnt_q + 1'b1;
            else                     wait_cnt_q <= '0;
            if (timeout) mem_err_q <= 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
    assign mem_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            case (state_q)
                StIdle:    if (run) state_q <= StFetch;
                StFetch: begin
                    if (mem_ready)    state_q <= StDecode;
                    else if (timeout) state_q <= StTrap;
                end
                StDecode: begin
                    if (op == OP_LW || op == OP_SW) state_q <= StMemAddr;
                    else if (op == 6'b000000)       state_q <= StRExec;
                    else if (op == OP_BEQ)          state_q <= StBranch;
                    else if (op == OP_J)            state_q <= StJump;
                    else if (op == OP_ADDI)         state_q <= StIExec;
                    else                            state_q <= StTrap;
                end
                StMemAddr: begin
                    if (op == OP_LW)      state_q <= StMemRd;
                    else if (op == OP_SW) state_q <= StMemWr;
                    else                  state_q <= StTrap;
                end
                StMemRd: begin
                    if (mem_ready)    state_q <= StMemWb;
                    else if (timeout) state_q <= StTrap;
                end
                StMemWr: begin
                    if (mem_ready)    state_q <= StFetch;
                    else if (timeout) state_q <= StTrap;
                end
                StRExec:   state_q <= r_valid ? StRWb : StTrap;
                StIExec:   state_q <= StIWb;
                StMemWb, StRWb, StBranch, StJump, StIWb, StTrap: state_q <= StFetch;
                default:   state_q <= StIdle;
            endcase
        end
    end

    assign state = state_q;

    always_comb begin
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        i_or_d     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'd0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'd0;
        alu_ctrl   = '0;
        reg_dest   = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        instr_done = 1'b0;
        illegal_op = 1'b0;
        case (state_q)
            StFetch: begin
                mem_read  = 1'b1;
                alu_src_b = 2'd1;
                alu_ctrl  = AluAdd;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            StDecode: begin
                alu_src_b = 2'd3;
                alu_ctrl  = AluAdd;
            end
            StMemAddr: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                alu_ctrl  = AluAdd;
            end
            StMemRd: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            StMemWb: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end
            StMemWr: begin
                mem_write  = 1'b1;
                i_or_d     = 1'b1;
                instr_done = mem_ready;
            end
            StRExec: begin
                alu_src_a = 1'b1;
                alu_ctrl  = r_alu;
            end
            StRWb: begin
                reg_write  = 1'b1;
                reg_dest   = 1'b1;
                instr_done = 1'b1;
            end
            StBranch: begin
                alu_src_a  = 1'b1;
                alu_ctrl   = AluSub;
                pc_src     = 2'd1;
                pc_write   = zero;
                instr_done = 1'b1;
            end
            StJump: begin
                pc_src     = 2'd2;
                pc_write   = 1'b1;
                instr_done = 1'b1;
            end
            StIExec: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                alu_ctrl  = AluAdd;
            end
            StIWb: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            StTrap:  illegal_op = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mc_control.sv
// Directed self-checking bench for mc_control.
module tb_mc_control;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       run;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic [3:0] state;
    logic       mem_read, mem_write, i_or_d, ir_write, pc_write;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_ctrl;
    logic       reg_dest, reg_write, mem_to_reg, instr_done, illegal_op, mem_err;

    int checks = 0;
    int errors = 0;

    wire [19:0] all_out = {mem_read, mem_write, i_or_d, ir_write, pc_write, pc_src, alu_src_a,
                           alu_src_b, alu_ctrl, reg_dest, reg_write, mem_to_reg, instr_done,
                           illegal_op, mem_err};

    mc_control dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .state      (state),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .i_or_d     (i_or_d),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_ctrl   (alu_ctrl),
        .reg_dest   (reg_dest),
        .reg_write  (reg_write),
        .mem_to_reg (mem_to_reg),
        .instr_done (instr_done),
        .illegal_op (illegal_op),
        .mem_err    (mem_err)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle outputs.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse reset between edges, leaving the unit in IDLE.
    task automatic pulse_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; run = 1'b0; op = 6'd0; funct = 6'd0; zero = 1'b0; mem_ready = 1'b0;
        #12;
        checks++;
        if (state !== 4'd0 || all_out !== 20'd0) begin
            errors++;
            $display("FAIL reset_state: state=%0d outputs=%h required state=0 outputs=0",
                     state, all_out);
        end
        rst_n = 1'b1;
        run = 1'b1; op = 6'b000000; funct = 6'b100000; mem_ready = 1'b1;
        step(); step(); step();
        checks++;
        if (state !== 4'd7) begin
            errors++;
            $display("FAIL reach_r_exec: state=%0d required 7", state);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (state !== 4'd0 || all_out !== 20'd0) begin
            errors++;
            $display("FAIL async_reset: state=%0d outputs=%h required state=0 outputs=0",
                     state, all_out);
        end
        run = 1'b0;
        #3;
        rst_n = 1'b1;
        step(); step();
        checks++;
        if (state !== 4'd0 || all_out !== 20'd0) begin
            errors++;
            $display("FAIL idle_hold: state=%0d outputs=%h required state=0 outputs=0",
                     state, all_out);
        end
    endtask

    task automatic test_lw();
        int exp_s[6] = '{1, 2, 3, 4, 5, 1};
        int done_cnt = 0;
        pulse_reset();
        run = 1'b1; op = 6'b100011; mem_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            done_cnt += int'(instr_done);
            checks++;
            if (state !== 4'(exp_s[i]) || reg_write !== (exp_s[i] == 5) ||
                mem_to_reg !== (exp_s[i] == 5)) begin
                errors++;
                $display("FAIL lw_step%0d: state=%0d rw=%b m2r=%b required state=%0d rw/m2r=%b",
                         i, state, reg_write, mem_to_reg, exp_s[i], exp_s[i] == 5);
            end
            if (i == 0) begin
                checks++;
                if ({mem_read, i_or_d, ir_write, pc_write, alu_src_a, alu_src_b, alu_ctrl}
                    !== {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 4'b0010}) begin
                    errors++;
                    $display("FAIL fetch_ctl: rd=%b iod=%b irw=%b pcw=%b a=%b b=%0d alu=%b",
                             mem_read, i_or_d, ir_write, pc_write, alu_src_a, alu_src_b,
                             alu_ctrl);
                end
            end
            if (i == 3) begin
                checks++;
                if (mem_read !== 1'b1 || i_or_d !== 1'b1 || mem_write !== 1'b0) begin
                    errors++;
                    $display("FAIL mem_rd_ctl: rd=%b iod=%b wr=%b required 1 1 0",
                             mem_read, i_or_d, mem_write);
                end
            end
        end
        checks++;
        if (done_cnt !== 1) begin
            errors++;
            $display("FAIL lw_done_count: got %0d required 1", done_cnt);
        end
    endtask

    task automatic test_rtype();
        logic [5:0] fn[4]  = '{6'b100000, 6'b100100, 6'b100101, 6'b101010};
        logic [3:0] alu[4] = '{4'b0010, 4'b0000, 4'b0001, 4'b0111};
        pulse_reset();
        run = 1'b1; op = 6'b000000; funct = 6'b100010; mem_ready = 1'b1;
        step(); step(); step();
        checks++;
        if (state !== 4'd7 || alu_ctrl !== 4'b0110 || alu_src_a !== 1'b1 || alu_src_b !== 2'd0)
        begin
            errors++;
            $display("FAIL r_exec_sub: state=%0d alu=%b a=%b b=%0d required 7 0110 1 0",
                     state, alu_ctrl, alu_src_a, alu_src_b);
        end
        step();
        checks++;
        if (state !== 4'd8 || reg_dest !== 1'b1 || reg_write !== 1'b1 || instr_done !== 1'b1) begin
            errors++;
            $display("FAIL r_wb: state=%0d rd=%b rw=%b done=%b required 8 1 1 1",
                     state, reg_dest, reg_write, instr_done);
        end
        step();
        for (int i = 0; i < 4; i++) begin
            funct = fn[i];
            step(); step();
            checks++;
            if (state !== 4'd7 || alu_ctrl !== alu[i]) begin
                errors++;
                $display("FAIL r_funct_%b: state=%0d alu=%b required 7 %b",
                         fn[i], state, alu_ctrl, alu[i]);
            end
            step(); step();
        end
        funct = 6'b000111;
        step(); step();
        checks++;
        if (state !== 4'd7 || alu_ctrl !== 4'b0000) begin
            errors++;
            $display("FAIL r_bad_funct: state=%0d alu=%b required 7 0000", state, alu_ctrl);
        end
        step();
        checks++;
        if (state !== 4'd13 || illegal_op !== 1'b1 || reg_write !== 1'b0 || pc_write !== 1'b0)
        begin
            errors++;
            $display("FAIL trap: state=%0d ill=%b rw=%b pcw=%b required 13 1 0 0",
                     state, illegal_op, reg_write, pc_write);
        end
        step();
        checks++;
        if (state !== 4'd1 || illegal_op !== 1'b0) begin
            errors++;
            $display("FAIL trap_exit: state=%0d ill=%b required 1 0", state, illegal_op);
        end
    endtask

    task automatic test_branch();
        pulse_reset();
        run = 1'b1; op = 6'b000100; zero = 1'b1; mem_ready = 1'b1;
        step(); step(); step();
        checks++;
        if (state !== 4'd9 || pc_write !== 1'b1 || pc_src !== 2'd1 || alu_ctrl !== 4'b0110 ||
            instr_done !== 1'b1) begin
            errors++;
            $display("FAIL beq_taken: state=%0d pcw=%b src=%0d alu=%b done=%b req 9 1 1 0110 1",
                     state, pc_write, pc_src, alu_ctrl, instr_done);
        end
        zero = 1'b0;
        #1;
        checks++;
        if (pc_write !== 1'b0) begin
            errors++;
            $display("FAIL beq_zero_comb: pcw=%b required 0", pc_write);
        end
        step();
        checks++;
        if (state !== 4'd1) begin
            errors++;
            $display("FAIL beq_exit: state=%0d required 1", state);
        end
        step(); step();
        checks++;
        if (state !== 4'd9 || pc_write !== 1'b0 || pc_src !== 2'd1) begin
            errors++;
            $display("FAIL beq_not_taken: state=%0d pcw=%b src=%0d required 9 0 1",
                     state, pc_write, pc_src);
        end
        step();
        checks++;
        if (state !== 4'd1) begin
            errors++;
            $display("FAIL beq_nt_exit: state=%0d required 1", state);
        end
    endtask

    task automatic test_jump_addi_illegal();
        pulse_reset();
        run = 1'b1; op = 6'b000010; mem_ready = 1'b1;
        step(); step(); step();
        checks++;
        if (state !== 4'd10 || pc_src !== 2'd2 || pc_write !== 1'b1 || instr_done !== 1'b1) begin
            errors++;
            $display("FAIL jump: state=%0d src=%0d pcw=%b done=%b required 10 2 1 1",
                     state, pc_src, pc_write, instr_done);
        end
        op = 6'b001000;
        step(); step(); step();
        checks++;
        if (state !== 4'd11 || alu_src_a !== 1'b1 || alu_src_b !== 2'd2 || reg_write !== 1'b0) begin
            errors++;
            $display("FAIL addi_exec: state=%0d a=%b b=%0d rw=%b required 11 1 2 0",
                     state, alu_src_a, alu_src_b, reg_write);
        end
        step();
        checks++;
        if (state !== 4'd12 || reg_write !== 1'b1 || reg_dest !== 1'b0 || instr_done !== 1'b1) begin
            errors++;
            $display("FAIL addi_wb: state=%0d rw=%b rd=%b done=%b required 12 1 0 1",
                     state, reg_write, reg_dest, instr_done);
        end
        op = 6'b111111;
        step(); step(); step();
        checks++;
        if (state !== 4'd13 || illegal_op !== 1'b1) begin
            errors++;
            $display("FAIL bad_op: state=%0d ill=%b required 13 1", state, illegal_op);
        end
    endtask

    task automatic test_back_to_back_sw_wait();
        int wr_cnt = 0;
        pulse_reset();
        run = 1'b1; op = 6'b101011; mem_ready = 1'b1;
        step(); step(); step();
        checks++;
        if (state !== 4'd3 || alu_src_b !== 2'd2) begin
            errors++;
            $display("FAIL sw_addr: state=%0d b=%0d required 3 2", state, alu_src_b);
        end
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            wr_cnt += int'(mem_write);
            checks++;
            if (state !== 4'd6 || mem_write !== 1'b1 || mem_read !== 1'b0 || i_or_d !== 1'b1 ||
                instr_done !== 1'b0) begin
                errors++;
                $display("FAIL sw_wait%0d: state=%0d wr=%b rd=%b iod=%b done=%b req 6 1 0 1 0",
                         i, state, mem_write, mem_read, i_or_d, instr_done);
            end
        end
        mem_ready = 1'b1;
        #1;
        wr_cnt += int'(mem_write);
        checks++;
        if (state !== 4'd6 || mem_write !== 1'b1 || instr_done !== 1'b1) begin
            errors++;
            $display("FAIL sw_ready: state=%0d wr=%b done=%b required 6 1 1",
                     state, mem_write, instr_done);
        end
        step();
        checks++;
        if (state !== 4'd1 || wr_cnt !== 4) begin
            errors++;
            $display("FAIL sw_total: state=%0d write_cycles=%0d required 1 4", state, wr_cnt);
        end
    endtask

    task automatic test_timeout();
        pulse_reset();
        run = 1'b1; op = 6'b100011; mem_ready = 1'b0;
        step();
        checks++;
        if (state !== 4'd1 || mem_read !== 1'b1 || ir_write !== 1'b0 || pc_write !== 1'b0) begin
            errors++;
            $display("FAIL fetch_stall: state=%0d rd=%b irw=%b pcw=%b required 1 1 0 0",
                     state, mem_read, ir_write, pc_write);
        end
        for (int i = 0; i < 15; i++) step();
        checks++;
        if (state !== 4'd1 || mem_err !== 1'b0) begin
            errors++;
            $display("FAIL fetch_16: state=%0d err=%b required 1 0", state, mem_err);
        end
        step();
`ifdef MEM_TIMEOUT_EN
        checks++;
        if (state !== 4'd13 || mem_err !== 1'b1 || illegal_op !== 1'b1) begin
            errors++;
            $display("FAIL timeout_trap: state=%0d err=%b ill=%b required 13 1 1",
                     state, mem_err, illegal_op);
        end
        step();
        checks++;
        if (state !== 4'd1 || mem_err !== 1'b1 || illegal_op !== 1'b0) begin
            errors++;
            $display("FAIL err_sticky: state=%0d err=%b ill=%b required 1 1 0",
                     state, mem_err, illegal_op);
        end
`else
        checks++;
        if (state !== 4'd1 || mem_err !== 1'b0 || illegal_op !== 1'b0) begin
            errors++;
            $display("FAIL no_timeout: state=%0d err=%b ill=%b required 1 0 0",
                     state, mem_err, illegal_op);
        end
`endif
        pulse_reset();
        #1;
        checks++;
        if (state !== 4'd0 || mem_err !== 1'b0) begin
            errors++;
            $display("FAIL err_clear: state=%0d err=%b required 0 0", state, mem_err);
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_rtype();
        test_branch();
        test_jump_addi_illegal();
        test_back_to_back_sw_wait();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
